limiter_safety_ctrl: RTL and testbench

- Control block that sequences and configures the output limiter stage of the hearing-aid chain.
- Host writes limiter parameters into a staging bank. A commit applies them atomically at the next audio sample boundary.
- Exposure-protection FSM watches the limiter's limiting-active status. If limiting lasts too long, it drops the limit threshold by 6 dB, then ramps it back once the signal is quiet again.

---
 rtl/limiter_safety_ctrl_if.sv | 13 +
 rtl/limiter_safety_ctrl.sv | 178 +++++++++++++++++
 tb/tb_limiter_safety_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/limiter_safety_ctrl_if.sv
// Host configuration bus for the limiter control block: write handshake plus commit strobe.
interface limiter_safety_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_addr;
  logic [23:0] cfg_data;
  logic        cfg_commit;

  modport master (output cfg_valid, output cfg_addr, output cfg_data, output cfg_commit,
                  input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_data, input cfg_commit,
                  output cfg_ready);
endinterface

// File: rtl/limiter_safety_ctrl.sv
// Limiter parameter staging/commit and exposure-protection FSM that halves the
// threshold after sustained limiting and ramps it back once the signal is quiet.
module limiter_safety_ctrl #(
  parameter int          EXPOSURE_LEN      = 48000,
  parameter int          RECOVER_LEN       = 24000,
  parameter int          CNT_W             = 16,
  parameter logic [23:0] DEFAULT_THRESHOLD = 24'h600000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  limiter_safety_ctrl_if.slave  cfg,
  input  logic                  sample_valid,
  input  logic                  limiting_active,
  output logic                  lim_enable,
  output logic [23:0]           limit_threshold,
  output logic [7:0]            ratio,
  output logic [15:0]           attack_time,
  output logic [15:0]           release_time,
  output logic                  protect_active,
  output logic [7:0]            protect_events
);

  typedef enum logic [1:0] {S_NORMAL, S_PROTECT, S_RECOVER} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   exp_cnt_q, exp_cnt_d, rec_cnt_q, rec_cnt_d;
  logic [23:0]        ramp_q, ramp_d;
  logic [7:0]         events_q, events_d;
  logic               lim_en_q, lim_en_d;
  logic               pending_q, pending_d;
  logic [23:0]        stg_thr_q, stg_thr_d, com_thr_q, com_thr_d;
  logic [7:0]         stg_ratio_q, stg_ratio_d, com_ratio_q, com_ratio_d;
  logic [15:0]        stg_att_q, stg_att_d, com_att_q, com_att_d;
  logic [15:0]        stg_rel_q, stg_rel_d, com_rel_q, com_rel_d;

  logic [CNT_W-1:0]   exp_inc, rec_inc;
  logic [23:0]        ramp_base;
  logic [24:0]        ramp_sum;

  always_comb begin
    state_d     = state_q;
    exp_cnt_d   = exp_cnt_q;
    rec_cnt_d   = rec_cnt_q;
    ramp_d      = ramp_q;
    events_d    = events_q;
    lim_en_d    = lim_en_q;
    pending_d   = pending_q;
    stg_thr_d   = stg_thr_q;
    stg_ratio_d = stg_ratio_q;
    stg_att_d   = stg_att_q;
    stg_rel_d   = stg_rel_q;
    com_thr_d   = com_thr_q;
    com_ratio_d = com_ratio_q;
    com_att_d   = com_att_q;
    com_rel_d   = com_rel_q;
    exp_inc     = (exp_cnt_q == '1) ? exp_cnt_q : exp_cnt_q + CNT_W'(1);
    rec_inc     = (rec_cnt_q == '1) ? rec_cnt_q : rec_cnt_q + CNT_W'(1);
    ramp_base   = '0;
    ramp_sum    = '0;

    if (cfg.cfg_valid && !pending_q) begin
      case (cfg.cfg_addr)
        2'd0:    stg_thr_d   = cfg.cfg_data;
        2'd1:    stg_ratio_d = cfg.cfg_data[7:0];
        2'd2:    stg_att_d   = cfg.cfg_data[15:0];
        default: stg_rel_d   = cfg.cfg_data[15:0];
      endcase
    end

    // pending_q only rises the cycle after the strobe, so a sample in the commit cycle never applies it
    if (cfg.cfg_commit && !pending_q) pending_d = 1'b1;
    if (pending_q && sample_valid) begin
      com_thr_d   = stg_thr_q;
      com_ratio_d = stg_ratio_q;
      com_att_d   = stg_att_q;
      com_rel_d   = stg_rel_q;
      lim_en_d    = 1'b1;
      pending_d   = 1'b0;
    end

    if (state_q == S_RECOVER && ramp_q > com_thr_d) ramp_d = com_thr_d;

    if (sample_valid && lim_en_q) begin
      case (state_q)
        S_NORMAL: begin
          if (!limiting_active) begin
            exp_cnt_d = '0;
          end else if (exp_inc >= CNT_W'(EXPOSURE_LEN)) begin
            state_d   = S_PROTECT;
            exp_cnt_d = '0;
            events_d  = (events_q == 8'hFF) ? events_q : events_q + 8'd1;
          end else begin
            exp_cnt_d = exp_inc;
          end
        end
        S_PROTECT: begin
          if (limiting_active) begin
            rec_cnt_d = '0;
          end else if (rec_inc >= CNT_W'(RECOVER_LEN)) begin
            state_d   = S_RECOVER;
            rec_cnt_d = '0;
            ramp_d    = com_thr_d >> 1;
          end else begin
            rec_cnt_d = rec_inc;
          end
        end
        default: begin
          if (limiting_active) begin
            state_d   = S_PROTECT;
            rec_cnt_d = '0;
          end else begin
            ramp_base = (ramp_q > com_thr_d) ? com_thr_d : ramp_q;
            ramp_sum  = {1'b0, ramp_base} + {1'b0, com_thr_d >> 4};
            if (ramp_sum >= {1'b0, com_thr_d}) begin
              ramp_d  = com_thr_d;
              state_d = S_NORMAL;
            end else begin
              ramp_d  = ramp_sum[23:0];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_NORMAL;
      exp_cnt_q   <= '0;
      rec_cnt_q   <= '0;
      ramp_q      <= '0;
      events_q    <= '0;
      lim_en_q    <= 1'b0;
      pending_q   <= 1'b0;
      stg_thr_q   <= DEFAULT_THRESHOLD;
      stg_ratio_q <= 8'h40;
      stg_att_q   <= 16'h0040;
      stg_rel_q   <= 16'h0004;
      com_thr_q   <= DEFAULT_THRESHOLD;
      com_ratio_q <= 8'h40;
      com_att_q   <= 16'h0040;
      com_rel_q   <= 16'h0004;
    end else begin
      state_q     <= state_d;
      exp_cnt_q   <= exp_cnt_d;
      rec_cnt_q   <= rec_cnt_d;
      ramp_q      <= ramp_d;
      events_q    <= events_d;
      lim_en_q    <= lim_en_d;
      pending_q   <= pending_d;
      stg_thr_q   <= stg_thr_d;
      stg_ratio_q <= stg_ratio_d;
      stg_att_q   <= stg_att_d;
      stg_rel_q   <= stg_rel_d;
      com_thr_q   <= com_thr_d;
      com_ratio_q <= com_ratio_d;
      com_att_q   <= com_att_d;
      com_rel_q   <= com_rel_d;
    end
  end

  always_comb begin
    case (state_q)
      S_PROTECT: limit_threshold = com_thr_q >> 1;
      S_RECOVER: limit_threshold = ramp_q;
      default:   limit_threshold = com_thr_q;
    endcase
  end

  assign cfg.cfg_ready      = !pending_q;
  assign lim_enable         = lim_en_q;
  assign ratio              = com_ratio_q;
  assign attack_time        = com_att_q;
  assign release_time       = com_rel_q;
  assign protect_active     = (state_q != S_NORMAL);
  assign protect_events     = events_q;

endmodule

// File: tb/tb_limiter_safety_ctrl.sv
// Directed table-driven bench for limiter_safety_ctrl with short exposure/recovery lengths.
module tb_limiter_safety_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic        limiting_active = 1'b0;
  logic        lim_enable;
  logic [23:0] limit_threshold;
  logic [7:0]  ratio;
  logic [15:0] attack_time;
  logic [15:0] release_time;
  logic        protect_active;
  logic [7:0]  protect_events;

  int errors = 0;
  int checks = 0;

  limiter_safety_ctrl_if cfg_if ();

  limiter_safety_ctrl #(
    .EXPOSURE_LEN(4), .RECOVER_LEN(3), .CNT_W(16), .DEFAULT_THRESHOLD(24'h600000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg_if.slave),
    .sample_valid(sample_valid), .limiting_active(limiting_active),
    .lim_enable(lim_enable), .limit_threshold(limit_threshold), .ratio(ratio),
    .attack_time(attack_time), .release_time(release_time),
    .protect_active(protect_active), .protect_events(protect_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv, la, cv;
    logic [1:0]  ca;
    logic [23:0] cd;
    logic        cc;
    logic        rdy, en;
    logic [23:0] thr;
    logic        pa;
    logic [7:0]  ev;
  } vec_t;

  vec_t tbl[64];
  int   n_vec = 0;

  task automatic add(input logic sv, la, cv, input logic [1:0] ca, input logic [23:0] cd,
                     input logic cc, rdy, en, input logic [23:0] thr, input logic pa,
                     input logic [7:0] ev);
    tbl[n_vec] = '{sv, la, cv, ca, cd, cc, rdy, en, thr, pa, ev};
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, la, cv, input logic [1:0] ca, input logic [23:0] cd,
                       input logic cc);
    @(negedge clk);
    sample_valid      = sv;
    limiting_active   = la;
    cfg_if.cfg_valid  = cv;
    cfg_if.cfg_addr   = ca;
    cfg_if.cfg_data   = cd;
    cfg_if.cfg_commit = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_thr"}, 32'(limit_threshold), 32'h600000);
    chk({tag, "_en"}, 32'(lim_enable), 32'd0);
    chk({tag, "_rdy"}, 32'(cfg_if.cfg_ready), 32'd1);
    chk({tag, "_pa"}, 32'(protect_active), 32'd0);
    chk({tag, "_ev"}, 32'(protect_events), 32'd0);
    chk({tag, "_ratio"}, 32'(ratio), 32'h40);
    chk({tag, "_att"}, 32'(attack_time), 32'h0040);
    chk({tag, "_rel"}, 32'(release_time), 32'h0004);
  endtask

  initial begin
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_addr   = 2'd0;
    cfg_if.cfg_data   = 24'd0;
    cfg_if.cfg_commit = 1'b0;

    // Configure, commit, wait 5 cycles before the applying sample
    add(0,0,1,0,24'h400000,0, 1,0,24'h600000,0,0);
    add(0,0,1,1,24'h123455,0, 1,0,24'h600000,0,0);
    add(0,0,1,2,24'hAB1234,0, 1,0,24'h600000,0,0);
    add(0,0,1,3,24'h005678,1, 0,0,24'h600000,0,0);
    for (int i = 0; i < 4; i++) add(0,0,0,0,0,0, 0,0,24'h600000,0,0);
    add(1,0,0,0,0,0, 1,1,24'h400000,0,0);
    // Limiting pattern 1,(idle),1,1,0,1,1,1 -> no protection yet
    add(1,1,0,0,0,0, 1,1,24'h400000,0,0);
    add(0,1,0,0,0,0, 1,1,24'h400000,0,0);
    add(1,1,0,0,0,0, 1,1,24'h400000,0,0);
    add(1,1,0,0,0,0, 1,1,24'h400000,0,0);
    add(1,0,0,0,0,0, 1,1,24'h400000,0,0);
    for (int i = 0; i < 3; i++) add(1,1,0,0,0,0, 1,1,24'h400000,0,0);
    add(1,1,0,0,0,0, 1,1,24'h200000,1,1);
    // PROTECT: interrupted quiet run, then 3 quiet samples -> RECOVER
    add(1,0,0,0,0,0, 1,1,24'h200000,1,1);
    add(1,1,0,0,0,0, 1,1,24'h200000,1,1);
    for (int i = 0; i < 3; i++) add(1,0,0,0,0,0, 1,1,24'h200000,1,1);
    add(1,0,0,0,0,0, 1,1,24'h240000,1,1);
    add(1,0,0,0,0,0, 1,1,24'h280000,1,1);
    add(1,1,0,0,0,0, 1,1,24'h200000,1,1);
    for (int i = 0; i < 3; i++) add(1,0,0,0,0,0, 1,1,24'h200000,1,1);
    for (int k = 1; k <= 8; k++)
      add(1,0,0,0,0,0, 1,1,24'h200000 + 24'(k) * 24'h040000, (k < 8), 1);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < n_vec; i++) begin
      drive(tbl[i].sv, tbl[i].la, tbl[i].cv, tbl[i].ca, tbl[i].cd, tbl[i].cc);
      $display("vec %0d sv=%0b la=%0b thr=%h pa=%0b ev=%0d rdy=%0b en=%0b", i, tbl[i].sv,
               tbl[i].la, limit_threshold, protect_active, protect_events,
               cfg_if.cfg_ready, lim_enable);
      chk($sformatf("v%0d_thr", i), 32'(limit_threshold), 32'(tbl[i].thr));
      chk($sformatf("v%0d_rdy", i), 32'(cfg_if.cfg_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_en", i), 32'(lim_enable), 32'(tbl[i].en));
      chk($sformatf("v%0d_pa", i), 32'(protect_active), 32'(tbl[i].pa));
      chk($sformatf("v%0d_ev", i), 32'(protect_events), 32'(tbl[i].ev));
    end
    chk("ratio", 32'(ratio), 32'h55);
    chk("attack", 32'(attack_time), 32'h1234);
    chk("release", 32'(release_time), 32'h5678);

    // Write+commit on a sample cycle; second commit while pending must be ignored
    drive(1,0,1,0,24'h300000,1);
    $display("seq commit_on_sample thr=%h rdy=%0b", limit_threshold, cfg_if.cfg_ready);
    chk("same_cycle_thr", 32'(limit_threshold), 32'h400000);
    chk("same_cycle_rdy", 32'(cfg_if.cfg_ready), 32'd0);
    drive(0,0,1,0,24'h100000,1);
    $display("seq second_commit thr=%h rdy=%0b", limit_threshold, cfg_if.cfg_ready);
    chk("pending_rdy", 32'(cfg_if.cfg_ready), 32'd0);
    drive(1,0,0,0,0,0);
    $display("seq apply thr=%h rdy=%0b", limit_threshold, cfg_if.cfg_ready);
    chk("applied_thr", 32'(limit_threshold), 32'h300000);
    chk("applied_rdy", 32'(cfg_if.cfg_ready), 32'd1);
    drive(1,0,0,0,0,0);
    chk("no_second_apply_rdy", 32'(cfg_if.cfg_ready), 32'd1);
    chk("no_second_apply_thr", 32'(limit_threshold), 32'h300000);

    // Enter PROTECT again, then commit a new threshold while protected
    for (int i = 0; i < 4; i++) drive(1,1,0,0,0,0);
    $display("seq protect2 thr=%h pa=%0b ev=%0d", limit_threshold, protect_active, protect_events);
    chk("protect2_thr", 32'(limit_threshold), 32'h180000);
    chk("protect2_ev", 32'(protect_events), 32'd2);
    drive(0,1,1,0,24'h200000,1);
    drive(1,1,0,0,0,0);
    $display("seq commit_in_protect thr=%h pa=%0b", limit_threshold, protect_active);
    chk("commit_protect_thr", 32'(limit_threshold), 32'h100000);
    chk("commit_protect_pa", 32'(protect_active), 32'd1);

    // Asynchronous reset mid-PROTECT, sampled before any clock edge
    @(negedge clk);
    sample_valid = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_commit = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    $display("seq async_reset thr=%h pa=%0b ev=%0d", limit_threshold, protect_active, protect_events);
    chk_reset_vals("async_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
